// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared state encoding and sizing helper for sorting_engine
package sort_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMP,
      SWAP,
      PASS_END,
      DONE
   } state_t;

   // Swap counter must hold n*(n-1)/2 swaps for n = 2^l, which always fits in 2l bits.
   function automatic int swap_cnt_width(input int l);
      return 2 * l;
   endfunction

endpackage

// File: rtl/sort_cmp.sv
// rtl/sort_cmp.sv - combinational out-of-order test for one adjacent pair
module sort_cmp
   import sort_pkg::*;
#(
   parameter int N      = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         Desc,
   output logic         OutOfOrder
);

   logic gt;
   logic lt;

   generate
      if (SIGNED) begin : g_signed
         assign gt = $signed(A) > $signed(B);
         assign lt = $signed(A) < $signed(B);
      end else begin : g_unsigned
         assign gt = A > B;
         assign lt = A < B;
      end
   endgenerate

   // Strict compares only, so equal keys stay put and the sort is stable.
   assign OutOfOrder = Desc ? lt : gt;

endmodule

// File: rtl/sorting_engine.sv
// rtl/sorting_engine.sv - in-place early-exit bubble sort over a host-loaded 2^L array
module sorting_engine
   import sort_pkg::*;
#(
   parameter int N      = 8,
   parameter int L      = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           Rd,
   input  logic                           WrInit,
   input  logic [L-1:0]                   RAddr,
   input  logic [N-1:0]                   DataIn,
   input  logic                           start,
   input  logic [L:0]                     Len,
   input  logic                           Desc,
   output logic [N-1:0]                   DataOut,
   output logic                           busy,
   output logic                           done,
   output logic [swap_cnt_width(L)-1:0]   SwapCnt
);

   localparam int DEPTH = 1 << L;
   localparam int SW    = swap_cnt_width(L);

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   mem [DEPTH];
   logic [L-1:0]   j;
   logic [L-1:0]   j_inc;
   logic [L-1:0]   lim;
   logic           swapped;
   logic           desc_q;
   logic [L:0]     n_clamp;
   logic           run_short;
   logic           last_cmp;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_of_order;

   assign n_clamp   = (Len > (L+1)'(DEPTH)) ? (L+1)'(DEPTH) : Len;
   assign run_short = (n_clamp <= (L+1)'(1));
   assign j_inc     = j + L'(1);
   assign last_cmp  = (j == lim - L'(1));
   assign a         = mem[j];
   assign b         = mem[j_inc];

   sort_cmp #(
      .N      (N),
      .SIGNED (SIGNED)
   ) u_cmp (
      .A          (a),
      .B          (b),
      .Desc       (desc_q),
      .OutOfOrder (out_of_order)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = run_short ? DONE : CMP;
            end
         end
         CMP: begin
            busy = 1'b1;
            if (out_of_order) begin
               state_nxt = SWAP;
            end else if (last_cmp) begin
               state_nxt = PASS_END;
            end
         end
         SWAP: begin
            busy      = 1'b1;
            state_nxt = last_cmp ? PASS_END : CMP;
         end
         PASS_END: begin
            busy      = 1'b1;
            state_nxt = (!swapped || lim == L'(1)) ? DONE : CMP;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         DataOut <= '0;
         SwapCnt <= '0;
         j       <= '0;
         lim     <= '0;
         swapped <= 1'b0;
         desc_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Rd) begin
                  DataOut <= mem[RAddr];
               end
               if (start) begin
                  desc_q  <= Desc;
                  j       <= '0;
                  lim     <= L'(n_clamp - (L+1)'(1));
                  swapped <= 1'b0;
                  SwapCnt <= '0;
               end
            end
            CMP: begin
               if (!out_of_order && !last_cmp) begin
                  j <= j_inc;
               end
            end
            SWAP: begin
               swapped <= 1'b1;
               SwapCnt <= SwapCnt + SW'(1);
               if (!last_cmp) begin
                  j <= j_inc;
               end
            end
            PASS_END: begin
               if (swapped && lim != L'(1)) begin
                  lim     <= lim - L'(1);
                  j       <= '0;
                  swapped <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Array has no reset; both halves of a swap land on the same edge so it stays a permutation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == IDLE && WrInit) begin
            mem[RAddr] <= DataIn;
         end else if (state == SWAP) begin
            mem[j]     <= b;
            mem[j_inc] <= a;
         end
      end
   end

endmodule

// File: tb/tb_sorting_engine.sv
// tb/tb_sorting_engine.sv - scoreboard bench for sorting_engine, unsigned and signed builds side by side
module tb_sorting_engine;

   localparam int N     = 8;
   localparam int L     = 4;
   localparam int DEPTH = 16;

   typedef int arr_t [DEPTH];
   typedef struct {
      int start_cyc;
      int done_cyc;
      int sw;
   } done_exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             Rd = 1'b0;
   logic             WrInit = 1'b0;
   logic [L-1:0]     RAddr = '0;
   logic [N-1:0]     DataIn = '0;
   logic             start = 1'b0;
   logic [L:0]       Len = '0;
   logic             Desc = 1'b0;
   logic [N-1:0]     data_out [2];
   logic             busy [2];
   logic             done [2];
   logic [2*L-1:0]   swap_cnt [2];

   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   done_exp_t        exp_done [2][$];
   int               exp_rd [2][$];
   logic             rd_pend = 1'b0;
   bit               perm_mode = 1'b0;
   int               busy_cnt [2] = '{0, 0};
   bit               got_done [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   sorting_engine #(.N(N), .L(L), .SIGNED(1'b0)) dut_u (
      .clk(clk), .rst(rst), .Rd(Rd), .WrInit(WrInit), .RAddr(RAddr), .DataIn(DataIn),
      .start(start), .Len(Len), .Desc(Desc), .DataOut(data_out[0]), .busy(busy[0]),
      .done(done[0]), .SwapCnt(swap_cnt[0])
   );

   sorting_engine #(.N(N), .L(L), .SIGNED(1'b1)) dut_s (
      .clk(clk), .rst(rst), .Rd(Rd), .WrInit(WrInit), .RAddr(RAddr), .DataIn(DataIn),
      .start(start), .Len(Len), .Desc(Desc), .DataOut(data_out[1]), .busy(busy[1]),
      .done(done[1]), .SwapCnt(swap_cnt[1])
   );

   task automatic check(input string name, input int k, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s inst%0d: got %0d expected %0d", name, k, got, expv);
      end
   endtask

   function automatic int key(input int v, input bit sgn);
      logic signed [7:0] sb;
      sb = v[7:0];
      return sgn ? int'(sb) : int'(v[7:0]);
   endfunction

   function automatic bit misordered(input int x, input int y, input bit desc, input bit sgn);
      return desc ? (key(x, sgn) < key(y, sgn)) : (key(x, sgn) > key(y, sgn));
   endfunction

   // Reference: swaps = inversion count; result and timing from pass-by-pass early-exit bubble.
   task automatic model(input arr_t a, input int n, input bit desc, input bit sgn,
                        output arr_t r, output int sw, output int dc);
      int lat;
      int lim;
      int tot;
      int t;
      bit s;
      bit fin;
      r  = a;
      sw = 0;
      for (int x = 0; x < n; x++)
         for (int y = x + 1; y < n; y++)
            if (misordered(a[x], a[y], desc, sgn)) sw++;
      if (n <= 1) begin
         dc = 1;
      end else begin
         lat = 0;
         tot = 0;
         lim = n - 1;
         fin = 1'b0;
         while (!fin) begin
            s = 1'b0;
            for (int p = 0; p < lim; p++) begin
               if (misordered(r[p], r[p+1], desc, sgn)) begin
                  t = r[p]; r[p] = r[p+1]; r[p+1] = t;
                  s = 1'b1;
                  tot++;
               end
            end
            lat += lim + 1;
            if (!s || lim == 1) fin = 1'b1;
            else lim--;
         end
         dc = lat + tot + 1;
      end
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_pend <= Rd && !perm_mode && !rst;
   end

   always @(negedge clk) begin
      done_exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (busy[k]) busy_cnt[k]++;
         if (done[k]) begin
            if (exp_done[k].size() == 0) begin
               check("unexpected_done", k, 1, 0);
            end else begin
               e = exp_done[k].pop_front();
               check("done_cycle", k, cyc - e.start_cyc, e.done_cyc);
               check("swap_cnt", k, int'(swap_cnt[k]), e.sw);
               check("busy_cycles", k, busy_cnt[k], e.done_cyc - 1);
            end
            got_done[k] = 1'b1;
            busy_cnt[k] = 0;
         end
         if (rst) busy_cnt[k] = 0;
         if (rd_pend) begin
            if (exp_rd[k].size() == 0) check("unexpected_read", k, 1, 0);
            else check("read_data", k, int'(data_out[k]), exp_rd[k].pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input arr_t a);
      for (int i = 0; i < DEPTH; i++) begin
         WrInit = 1'b1;
         RAddr  = L'(i);
         DataIn = N'(a[i]);
         tick();
      end
      WrInit = 1'b0;
   endtask

   task automatic run(input arr_t a, input int len, input bit desc, input bit junk);
      arr_t      r [2];
      int        sw;
      int        dc;
      int        n;
      done_exp_t e;
      load(a);
      n = (len > DEPTH) ? DEPTH : len;
      for (int k = 0; k < 2; k++) begin
         model(a, n, desc, k[0], r[k], sw, dc);
         e.start_cyc = cyc;
         e.done_cyc  = dc;
         e.sw        = sw;
         exp_done[k].push_back(e);
         got_done[k] = 1'b0;
      end
      start = 1'b1;
      Len   = (L+1)'(len);
      Desc  = desc;
      tick();
      start = 1'b0;
      if (junk && n >= 2) begin
         WrInit = 1'b1;
         RAddr  = L'($urandom);
         DataIn = N'($urandom);
         start  = 1'b1;
         Desc   = ~desc;
         Len    = (L+1)'($urandom);
         tick();
         WrInit = 1'b0;
         start  = 1'b0;
      end
      for (int t = 0; t < 2000 && !(got_done[0] && got_done[1]); t++) tick();
      if (!(got_done[0] && got_done[1])) check("done_timeout", 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) begin
         Rd    = 1'b1;
         RAddr = L'(i);
         exp_rd[0].push_back(r[0][i] & 255);
         exp_rd[1].push_back(r[1][i] & 255);
         tick();
      end
      Rd = 1'b0;
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int k = 0; k < 2; k++) begin
         check({tag, "_busy"}, k, int'(busy[k]), 0);
         check({tag, "_done"}, k, int'(done[k]), 0);
         check({tag, "_dataout"}, k, int'(data_out[k]), 0);
         check({tag, "_swapcnt"}, k, int'(swap_cnt[k]), 0);
      end
   endtask

   task automatic reset_mid_sort();
      arr_t a;
      int   got [2][$];
      int   ref_q [$];
      for (int i = 0; i < DEPTH; i++) a[i] = 200 - 3 * i;
      load(a);
      start = 1'b1;
      Len   = (L+1)'(DEPTH);
      Desc  = 1'b0;
      tick();
      start = 1'b0;
      repeat (37) tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("midreset");
      rst = 1'b0;
      perm_mode = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         Rd    = 1'b1;
         RAddr = L'(i);
         tick();
         got[0].push_back(int'(data_out[0]));
         got[1].push_back(int'(data_out[1]));
      end
      Rd = 1'b0;
      tick();
      perm_mode = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_q.push_back(a[i] & 255);
      ref_q.sort();
      for (int k = 0; k < 2; k++) begin
         got[k].sort();
         for (int i = 0; i < DEPTH; i++) check("perm_after_reset", k, got[k][i], ref_q[i]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog inst0: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arr_t a;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      for (int i = 0; i < DEPTH; i++) a[i] = int'($urandom_range(0, 255));
      a[0] = 5; a[1] = 3; a[2] = 7; a[3] = 1; a[4] = 0; a[5] = 6; a[6] = 2; a[7] = 4;
      run(a, 8, 1'b0, 1'b0);
      run(a, 8, 1'b1, 1'b0);

      for (int i = 0; i < 8; i++) a[i] = i;
      run(a, 8, 1'b0, 1'b0);

      a[0] = 'h80; a[1] = 'h7F; a[2] = 'hFF; a[3] = 'h00;
      run(a, 4, 1'b0, 1'b0);

      for (int i = 0; i < DEPTH; i++) a[i] = 9 - i + 100 * (i / 4);
      run(a, 3, 1'b0, 1'b0);

      for (int i = 0; i < DEPTH; i++) a[i] = int'($urandom_range(0, 255));
      run(a, 1, 1'b0, 1'b0);
      run(a, 0, 1'b1, 1'b0);
      run(a, 20, 1'b0, 1'b0);

      reset_mid_sort();

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < DEPTH; i++) a[i] = int'($urandom_range(0, 255));
         if (r % 3 == 0)
            for (int i = 0; i < DEPTH; i++) a[i] = a[i] % 4;
         run(a, int'($urandom_range(0, 20)), 1'($urandom), 1'b1);
      end

      for (int k = 0; k < 2; k++) begin
         check("leftover_done", k, exp_done[k].size(), 0);
         check("leftover_reads", k, exp_rd[k].size(), 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
